// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 keyboard receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int c_EVT_W = 10;

    typedef struct packed {
        logic       rel;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] c_PFX_E0 = 8'hE0;
    localparam logic [7:0] c_PFX_E1 = 8'hE1;
    localparam logic [7:0] c_PFX_F0 = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Keyboard status/acknowledge bytes that never become key events.
    function automatic logic is_status_code(input logic [7:0] code);
        return code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_evt_fifo
//  Purpose  : Small first-word-fall-through FIFO for keyboard events.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                       (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk_sys) begin
            if (!reset_n)
                r_mem[i] <= '0;
            else if (w_do_push && (r_wr_ptr[c_AW-1:0] == c_AW'(i)))
                r_mem[i] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_kbd_rx
//  Purpose  : PS/2 keyboard frame receiver, prefix decoder and event FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 28000000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ps2_kbd_clk,
    input  logic               ps2_kbd_data,
    output logic [c_EVT_W-1:0] ev_data,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic               frame_err,
    output logic               overflow
);

    localparam int c_TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int c_TO_W   = $clog2(c_TO_CYC + 1);

    logic              r_data_s1, r_data_s2;
    logic              r_clk_s1, r_clk_s2;
    logic [3:0]        r_clk_sr;
    logic              r_clk_filt, r_clk_filt_d;
    logic              w_strike;
    rx_state_t         r_state;
    logic [2:0]        r_bit_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_shift;
    logic              r_par_ok;
    logic              r_byte_stb;
    logic              r_frame_err;
    logic              r_ext, r_rel, r_overflow;
    logic              w_push, w_pop, w_empty, w_full;
    ps2_evt_t          w_evt;

    // Sync flops idle high like the bus, so reset release cannot fake an edge.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_data_s1    <= 1'b1;
            r_data_s2    <= 1'b1;
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_clk_sr     <= 4'b1111;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_data_s1    <= ps2_kbd_data;
            r_data_s2    <= r_data_s1;
            r_clk_s1     <= ps2_kbd_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_sr     <= {r_clk_sr[2:0], r_clk_s2};
            if (r_clk_sr == 4'b0000)      r_clk_filt <= 1'b0;
            else if (r_clk_sr == 4'b1111) r_clk_filt <= 1'b1;
            r_clk_filt_d <= r_clk_filt;
        end
    end

    assign w_strike = r_clk_filt_d & ~r_clk_filt;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_to_cnt    <= '0;
            r_shift     <= 8'h00;
            r_par_ok    <= 1'b0;
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_strike || r_state == ST_IDLE) r_to_cnt <= '0;
            else                                r_to_cnt <= r_to_cnt + c_TO_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (w_strike && !r_data_s2) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (w_strike) begin
                        r_shift   <= {r_data_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (w_strike) begin
                        r_par_ok <= ^{r_data_s2, r_shift};
                        r_state  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_strike) begin
                        r_state <= ST_IDLE;
                        if (r_data_s2 && r_par_ok) r_byte_stb  <= 1'b1;
                        else                       r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Keyboard went silent mid-frame: abandon it.
            if (!w_strike && r_state != ST_IDLE &&
                r_to_cnt == c_TO_W'(c_TO_CYC - 1)) begin
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign w_push = r_byte_stb && r_shift != c_PFX_E0 && r_shift != c_PFX_F0 &&
                    r_shift != c_PFX_E1 && !is_status_code(r_shift);
    assign w_pop  = ev_valid & ev_ready;
    assign w_evt  = '{rel: r_rel, ext: r_ext, code: r_shift};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_byte_stb) begin
                if (r_shift == c_PFX_E0)      r_ext <= 1'b1;
                else if (r_shift == c_PFX_F0) r_rel <= 1'b1;
                else if (r_shift != c_PFX_E1) begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (4),
        .WIDTH (c_EVT_W)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_evt),
        .i_pop       (w_pop),
        .o_head      (ev_data),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

    assign ev_valid  = ~w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_kbd_rx
//  Purpose  : Directed self-checking bench for the PS/2 keyboard receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       ev_ready;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       frame_err;
    logic       overflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         ferr_cnt = 0;
    int         valid_cyc = 0;
    logic [9:0] popped [$];

    always #5 clk_sys = ~clk_sys;

    // 1 MHz, 100 us gives a 100-cycle timeout; bits are ~23 cycles apart.
    ps2_kbd_rx #(
        .CLK_HZ     (1000000),
        .TIMEOUT_US (100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .ev_data      (ev_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always @(negedge clk_sys) begin
        if (reset_n === 1'b1) begin
            if (ev_valid === 1'b1) valid_cyc++;
            if (ev_valid === 1'b1 && ev_ready === 1'b1) popped.push_back(ev_data);
            if (frame_err === 1'b1) ferr_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clr();
        popped.delete();
        ferr_cnt  = 0;
        valid_cyc = 0;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_kbd_data = b;
        cyc(8);
        if (glitch) begin
            ps2_kbd_clk = 1'b0;
            cyc(1);
            ps2_kbd_clk = 1'b1;
        end
        cyc(4);
        ps2_kbd_clk = 1'b0;
        cyc(10);
        ps2_kbd_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit((~^d) ^ bad_par, glitch);
        send_bit(1'b1, glitch);
        ps2_kbd_data = 1'b1;
        cyc(20);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ps2_kbd_clk = 1'b1; ps2_kbd_data = 1'b1; ev_ready = 1'b1;
        cyc(4);
        n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid got %b want 0", ev_valid); end
        n_tests++; if (ev_data !== 10'h000) begin n_fail++; $display("FAIL reset_ev_data got %h want 000", ev_data); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset_n = 1'b1;
        clr();
        cyc(20);
        n_tests++; if (valid_cyc !== 0 || ferr_cnt !== 0) begin n_fail++; $display("FAIL reset_release valid_cyc %0d ferr %0d want 0 0", valid_cyc, ferr_cnt); end
    endtask

    task automatic test_single();
        clr();
        send_frame(8'h1C, 1'b0, 1'b0);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h01C) begin n_fail++; $display("FAIL single_data got %h want 01c", popped[0]); end
        end
        n_tests++; if (valid_cyc !== 1) begin n_fail++; $display("FAIL single_valid_cycles got %0d want 1", valid_cyc); end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_frame_err got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_prefix();
        clr();
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b0);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL prefix_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h36B) begin n_fail++; $display("FAIL prefix_data got %h want 36b", popped[0]); end
        end
    endtask

    task automatic test_parity();
        clr();
        send_frame(8'h1C, 1'b1, 1'b0);
        n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL parity_frame_err got %0d want 1", ferr_cnt); end
        n_tests++; if (popped.size() !== 0) begin n_fail++; $display("FAIL parity_no_event got %0d want 0", popped.size()); end
        clr();
        send_frame(8'h1B, 1'b0, 1'b0);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL parity_next_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h01B) begin n_fail++; $display("FAIL parity_next_data got %h want 01b", popped[0]); end
        end
    endtask

    task automatic test_timeout();
        clr();
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1 ^ 1'b1);
        send_bit(1'b1, 1'b0);
        ps2_kbd_data = 1'b1;
        cyc(150);
        n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL timeout_frame_err got %0d want 1", ferr_cnt); end
        n_tests++; if (popped.size() !== 0) begin n_fail++; $display("FAIL timeout_no_event got %0d want 0", popped.size()); end
        clr();
        send_frame(8'h29, 1'b0, 1'b0);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL timeout_next_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h029) begin n_fail++; $display("FAIL timeout_next_data got %h want 029", popped[0]); end
        end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL timeout_next_frame_err got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16};
        logic [9:0] exp_q [4] = '{10'h015, 10'h01D, 10'h024, 10'h02D};
        clr();
        ev_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_frame(codes[i], 1'b0, 1'b0);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b want 1", ev_valid); end
        ev_ready = 1'b1;
        cyc(10);
        n_tests++; if (popped.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 4", popped.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= popped.size()) begin n_fail++; $display("FAIL ovf_drain_%0d missing want %h", i, exp_q[i]); end
            else if (popped[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_drain_%0d got %h want %h", i, popped[i], exp_q[i]); end
        end
        n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", ev_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_glitch_reset();
        clr();
        send_frame(8'h5A, 1'b0, 1'b1);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h05A) begin n_fail++; $display("FAIL glitch_data got %h want 05a", popped[0]); end
        end
        clr();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        ps2_kbd_data = 1'b1;
        cyc(150);
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL midreset_frame_err got %0d want 0", ferr_cnt); end
        n_tests++; if (popped.size() !== 0) begin n_fail++; $display("FAIL midreset_no_event got %0d want 0", popped.size()); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_overflow got %b want 0", overflow); end
        clr();
        send_frame(8'h4D, 1'b0, 1'b1);
        n_tests++; if (popped.size() !== 1) begin n_fail++; $display("FAIL midreset_next_count got %0d want 1", popped.size()); end
        else begin
            n_tests++; if (popped[0] !== 10'h04D) begin n_fail++; $display("FAIL midreset_next_data got %h want 04d", popped[0]); end
        end
        n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL midreset_next_frame_err got %0d want 0", ferr_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_overflow();
        test_glitch_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter CLK_HZ, default 28000000, frequency of clk_sys in Hz.
REQ-002 Parameter TIMEOUT_US, default 2000, maximum gap between PS/2 clock falling edges inside one frame.
REQ-003 Port clk_sys  input  1  system clock; all logic sits on its rising edge.
REQ-004 Port reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port ps2_kbd_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 Port ps2_kbd_data  input  1  raw PS/2 data line, asynchronous.
REQ-007 Port ev_data  output  10  event word {release, extended, code[7:0]}.
REQ-008 Port ev_valid  output  1  ev_data holds an event.
REQ-009 Port ev_ready  input  1  consumer accepts the event when ev_valid and ev_ready are both high.
REQ-010 Port frame_err  output  1  one-cycle pulse on a parity, stop or timeout error.
REQ-011 Port overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-012 Synchronise ps2_kbd_data through 2 flops, and ps2_kbd_clk through 2 flops followed by a 4-bit sample shift register.
REQ-013 Filtered clock goes to 0 when all 4 samples are 0 and to 1 when all 4 are 1; otherwise it holds its value.
REQ-014 A 1-to-0 transition of the filtered clock is a sample strike; synchronised data is taken on that cycle.
REQ-015 Receiver FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: a strike with data 0 goes to DATA; a strike with data 1 is ignored.
REQ-016 DATA collects 8 bits LSB first, using a 3-bit counter, then moves to PARITY.
- PARITY requires odd parity over the data and parity bits.
- STOP requires data 1.
- STOP always returns to IDLE.
REQ-017 A parity or stop failure discards the byte and pulses frame_err in the cycle after the stop strike.
REQ-018 In any non-IDLE state, CLK_HZ/1000000*TIMEOUT_US cycles without a strike:
- return to IDLE;
- pulse frame_err;
- discard partial data.
- The counter reloads on every strike.
REQ-019 A valid byte asserts byte_stb for exactly 1 cycle, the cycle after the stop strike.
REQ-020 Prefix decoder, acting on byte_stb:
- E0 sets ext.
- F0 sets rel.
- E1 is discarded and leaves the flags unchanged.
- AA, FA, FE, EE, 00 and FF are discarded and clear both flags.
- Any other byte pushes {rel, ext, byte} and clears both flags.
REQ-021 Event FIFO: 4 entries × 10 bits, pointers of width 2 plus a wrap bit.
- ev_valid = not empty.
- ev_data = head entry, shown in first-word-fall-through fashion.
REQ-022 Push timing: written on the clock edge that ends the byte_stb cycle.
- With the FIFO empty, ev_valid rises 2 cycles after the stop strike.
REQ-023 Pop happens when ev_valid and ev_ready are high; the head advances on that edge.
REQ-024 Push while full without a simultaneous pop: the event is dropped and overflow is set.
- Push and pop in the same cycle while full: both happen and the count stays 4.
REQ-025 Push and pop in the same cycle while empty: the push happens, the pop is ignored, and ev_valid rises next cycle.
REQ-026 Pointers wrap from 3 to 0; full is indicated by equal indices with differing wrap bits.
REQ-027 A strike arriving during byte_stb or a push is handled normally; the receiver never stalls on the FIFO.

Reset
REQ-028 While reset_n is 0 at a rising edge, the following are cleared:
- FSM = IDLE, bit counter = 0, timeout counter = 0;
- ext = rel = 0;
- FIFO empty (ev_valid = 0), ev_data = 0;
- frame_err = 0, overflow = 0.
REQ-029 The filter shift register resets to 4'b1111 and the filtered clock to 1, so releasing reset creates no false strike.
REQ-030 Reset during a frame abandons the frame with no frame_err and no event.

Structure
REQ-031 A shared package ps2_pkg holds:
- the event typedef {release, extended, code};
- prefix constants E0, E1 and F0;
- the set of discarded status codes;
- the receiver-state enum.
REQ-032 One sub-module, ps2_evt_fifo: parameterised depth and width, synchronous, active-low reset, first-word-fall-through.

Verification
REQ-033 Frame for 0x1C with correct parity, ev_ready = 1 → one event 0x01C, ev_valid high 1 cycle, frame_err stays 0.
REQ-034 Sequence E0 F0 6B → single event 0x36B (release = 1, extended = 1); no events for the prefix bytes.
REQ-035 Frame 0x1C with even parity → frame_err pulses once, no event, and a following good 0x1B yields 0x01B.
REQ-036 Start bit plus 3 data bits, then clock held high past the timeout → frame_err pulse, FSM back in IDLE, then a good 0x29 yields 0x029.
REQ-037 ev_ready = 0, six make codes 15 1D 24 2D 2C 16 sent → overflow = 1, and the FIFO drains 0x015 0x01D 0x024 0x02D in order.
REQ-038 Single-cycle 0 glitches on ps2_kbd_clk between edges, plus reset_n pulsed low mid-frame → no strike from the glitches, no event, no frame_err, and the next frame is received correctly.
